// File: rtl/imem_loader_if.sv
// imem_loader_if: host byte link and instruction-memory write port of the loader.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    modport master (output rx_data, rx_valid, input rx_ready, mem_we, mem_waddr, mem_wdata);
    modport slave  (input rx_data, rx_valid, output rx_ready, mem_we, mem_waddr, mem_wdata);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: byte-serial big-endian instruction loader with trailing additive checksum.
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [CNT_W-1:0]  word_count_i,
    imem_loader_if.slave      bus,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  words_written_o
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_CKSUM  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;
    localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1 << ADDR_W);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  word_idx_q, word_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       shift_q, shift_d;
    logic [31:0]       acc_q, acc_d;
    logic              err_q, err_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_sat;
    logic [31:0]       word;
    logic              accept;

    assign cnt_sat = (word_count_i > MAX_WORDS) ? MAX_WORDS : word_count_i;
    assign word    = {shift_q, bus.rx_data};
    assign accept  = bus.rx_valid && bus.rx_ready;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        acc_d      = acc_q;
        err_d      = err_q;
        mem_we_d   = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        if (state_q == S_IDLE && start_i) begin
            base_d     = base_addr_i;
            count_d    = cnt_sat;
            word_idx_d = '0;
            byte_idx_d = '0;
            acc_d      = '0;
            err_d      = 1'b0;
            state_d    = (cnt_sat == '0) ? S_CKSUM : S_LOAD;
        end else if (state_q == S_FINISH) begin
            state_d = S_IDLE;
        end else if (accept) begin
            shift_d    = word[23:0];
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3 && state_q == S_LOAD) begin
                mem_we_d   = 1'b1;
                waddr_d    = base_q + word_idx_q[ADDR_W-1:0];
                wdata_d    = word;
                acc_d      = acc_q + word;
                word_idx_d = word_idx_q + CNT_W'(1);
                state_d    = (word_idx_q + CNT_W'(1) == count_q) ? S_CKSUM : S_LOAD;
            end else if (byte_idx_q == 2'd3) begin
                err_d   = (word != acc_q);
                state_d = S_FINISH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            acc_q      <= '0;
            err_q      <= 1'b0;
            mem_we_q   <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            acc_q      <= acc_d;
            err_q      <= err_d;
            mem_we_q   <= mem_we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign bus.rx_ready    = (state_q == S_LOAD) || (state_q == S_CKSUM);
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_waddr   = waddr_q;
    assign bus.mem_wdata   = wdata_q;
    assign busy_o          = (state_q != S_IDLE);
    assign cpu_hold_o      = (state_q != S_IDLE);
    assign done_o          = (state_q == S_FINISH);
    assign err_o           = err_q;
    assign words_written_o = word_idx_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven loads with a write scoreboard, plus reset/idle corner sequences.
module tb_imem_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] base_addr_i = '0;
    logic [8:0] word_count_i = '0;
    logic       cpu_hold_o, busy_o, done_o, err_o;
    logic [8:0] words_written_o;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [39:0] exp_q[$];
    logic [39:0] e;
    logic        prev_we = 1'b0;

    imem_loader_if #(.ADDR_W(8)) bus();

    imem_loader dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
        .word_count_i(word_count_i), .bus(bus), .cpu_hold_o(cpu_hold_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o), .words_written_o(words_written_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] base;
        logic [8:0] cnt;
        logic       bad;
        int         gap;
        logic       poke;
        logic       fixed;
        logic       exp_err;
        logic [8:0] exp_words;
    } vec_t;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_we) begin
            chk("we_single_cycle", {39'b0, prev_we}, 40'd0);
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0h data %0h, none expected", bus.mem_waddr, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("waddr", {32'b0, bus.mem_waddr}, {32'b0, e[39:32]});
                chk("wdata", {8'b0, bus.mem_wdata}, {8'b0, e[31:0]});
            end
        end
        prev_we <= bus.mem_we;
    end

    task automatic send_byte(input logic [7:0] d, input int maxgap);
        int t;
        logic r;
        repeat (maxgap > 0 ? $urandom_range(0, maxgap) : 0) begin
            @(posedge clk);
            #1;
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = d;
        t = 0;
        do begin
            @(negedge clk);
            r = bus.rx_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!r && t < 100);
        if (!r) chk("byte_accept_timeout", 40'd0, 40'd1);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], maxgap);
    endtask

    task automatic run_load(input vec_t v);
        logic [31:0] acc, w;
        int n;
        n = (v.cnt > 9'd256) ? 256 : int'(v.cnt);
        acc = '0;
        start_i = 1'b1;
        base_addr_i = v.base;
        word_count_i = v.cnt;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        chk("busy_after_start", {39'b0, busy_o}, 40'd1);
        chk("hold_after_start", {39'b0, cpu_hold_o}, 40'd1);
        chk("ready_after_start", {39'b0, bus.rx_ready}, 40'd1);
        chk("err_cleared", {39'b0, err_o}, 40'd0);
        chk("words_cleared", {31'b0, words_written_o}, 40'd0);
        for (int i = 0; i < n; i++) begin
            w = v.fixed ? (i == 0 ? 32'h20080005 : 32'h20090007) : $urandom;
            exp_q.push_back({v.base + 8'(i), w});
            acc += w;
            send_word(w, v.gap);
            if (v.poke && i == 1) begin
                start_i = 1'b1;
                base_addr_i = 8'h77;
                word_count_i = 9'd1;
                @(posedge clk);
                #1;
                start_i = 1'b0;
            end
        end
        send_word(acc + {31'b0, v.bad}, v.gap);
        chk("done_pulse", {39'b0, done_o}, 40'd1);
        chk("err_at_done", {39'b0, err_o}, {39'b0, v.exp_err});
        chk("words_written", {31'b0, words_written_o}, {31'b0, v.exp_words});
        @(posedge clk);
        #1;
        chk("done_one_cycle", {39'b0, done_o}, 40'd0);
        chk("idle_busy", {39'b0, busy_o}, 40'd0);
        chk("idle_hold", {39'b0, cpu_hold_o}, 40'd0);
        chk("writes_drained", 40'(exp_q.size()), 40'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("err_sticky", {39'b0, err_o}, {39'b0, v.exp_err});
        chk("words_hold", {31'b0, words_written_o}, {31'b0, v.exp_words});
    endtask

    vec_t tbl[6];

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        tbl[0] = '{8'h00, 9'd2,   1'b0, 0, 1'b0, 1'b1, 1'b0, 9'd2};
        tbl[1] = '{8'h00, 9'd2,   1'b1, 0, 1'b0, 1'b1, 1'b1, 9'd2};
        tbl[2] = '{8'hFF, 9'd2,   1'b0, 3, 1'b0, 1'b0, 1'b0, 9'd2};
        tbl[3] = '{8'h00, 9'd0,   1'b0, 0, 1'b0, 1'b0, 1'b0, 9'd0};
        tbl[4] = '{8'hF0, 9'd300, 1'b0, 0, 1'b0, 1'b0, 1'b0, 9'd256};
        tbl[5] = '{8'h40, 9'd5,   1'b1, 2, 1'b1, 1'b0, 1'b1, 9'd5};
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_busy", {39'b0, busy_o}, 40'd0);
        chk("rst_done", {39'b0, done_o}, 40'd0);
        chk("rst_err", {39'b0, err_o}, 40'd0);
        chk("rst_words", {31'b0, words_written_o}, 40'd0);
        chk("rst_waddr", {32'b0, bus.mem_waddr}, 40'd0);
        chk("rst_wdata", {8'b0, bus.mem_wdata}, 40'd0);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_rx_ready", {39'b0, bus.rx_ready}, 40'd0);
            chk("idle_no_busy", {39'b0, busy_o}, 40'd0);
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        for (int i = 0; i < 6; i++) run_load(tbl[i]);

        // Abort a count=4 load after six bytes: the first word is already written.
        start_i = 1'b1;
        base_addr_i = 8'h10;
        word_count_i = 9'd4;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        exp_q.push_back({8'h10, 32'hDEADBEEF});
        send_word(32'hDEADBEEF, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_busy", {39'b0, busy_o}, 40'd0);
        chk("abort_ready", {39'b0, bus.rx_ready}, 40'd0);
        chk("abort_words", {31'b0, words_written_o}, 40'd0);
        chk("abort_waddr", {32'b0, bus.mem_waddr}, 40'd0);
        chk("abort_wdata", {8'b0, bus.mem_wdata}, 40'd0);
        chk("abort_one_write", 40'(exp_q.size()), 40'd0);
        run_load('{8'h10, 9'd4, 1'b0, 1, 1'b0, 1'b0, 1'b0, 9'd4});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
